// File: rtl/mul4x8x8_wallace.sv
// Four-lane unsigned 8x8 dot product: input capture, partial-product rows,
// Wallace carry-save reduction to two vectors, then a final carry-propagate add.
`timescale 1ns/1ps
module mul4x8x8_wallace (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  output logic [17:0] out_sum
);

  logic        in_vld_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        pp_vld_q;
  logic [15:0] pp_d [32];
  logic [15:0] pp_q [32];
  logic        csa_vld_q;
  logic [17:0] sum_vec_d;
  logic [17:0] cry_vec_d;
  logic [17:0] sum_vec_q;
  logic [17:0] cry_vec_q;
  logic        out_vld_q;
  logic [17:0] out_sum_d;
  logic [17:0] out_sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      in_vld_q <= in_valid;
      if (in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

  // Row gi belongs to byte product gi/8; bit gi of b gates that product's a byte.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pp
      assign pp_d[gi] = {8'b0, a_q[8*(gi/8) +: 8] & {8{b_q[gi]}}} << (gi % 8);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_vld_q <= 1'b0;
      for (int i = 0; i < 32; i++) pp_q[i] <= '0;
    end else begin
      pp_vld_q <= in_vld_q;
      if (in_vld_q) begin
        for (int i = 0; i < 32; i++) pp_q[i] <= pp_d[i];
      end
    end
  end

  // Eight Wallace layers of word-wide 3:2 compressors take 32 rows down to 2:
  // 32 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2. Rows not in a full triple pass through.
  always_comb begin
    logic [17:0] tree [32];
    logic [17:0] nxt [32];
    logic [17:0] x;
    logic [17:0] y;
    logic [17:0] z;
    logic [17:0] maj;
    int n;
    int g;
    int r;
    x = '0;
    y = '0;
    z = '0;
    maj = '0;
    for (int i = 0; i < 32; i++) begin
      tree[i] = {2'b0, pp_q[i]};
      nxt[i]  = '0;
    end
    n = 32;
    for (int l = 0; l < 8; l++) begin
      g = n / 3;
      r = n - 3 * g;
      for (int i = 0; i < 32; i++) nxt[i] = '0;
      for (int k = 0; k < 10; k++) begin
        if (k < g) begin
          x   = tree[3*k];
          y   = tree[3*k+1];
          z   = tree[3*k+2];
          maj = (x & y) | (x & z) | (y & z);
          nxt[2*k]   = x ^ y ^ z;
          nxt[2*k+1] = {maj[16:0], 1'b0};
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (k < r) nxt[2*g+k] = tree[3*g+k];
      end
      for (int i = 0; i < 32; i++) tree[i] = nxt[i];
      n = 2 * g + r;
    end
    sum_vec_d = tree[0];
    cry_vec_d = tree[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csa_vld_q <= 1'b0;
      sum_vec_q <= '0;
      cry_vec_q <= '0;
    end else begin
      csa_vld_q <= pp_vld_q;
      if (pp_vld_q) begin
        sum_vec_q <= sum_vec_d;
        cry_vec_q <= cry_vec_d;
      end
    end
  end

  // The true sum never exceeds 18 bits, so dropping the top carry is exact.
  assign out_sum_d = sum_vec_q + cry_vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_sum_q <= '0;
    end else begin
      out_vld_q <= csa_vld_q;
      if (csa_vld_q) out_sum_q <= out_sum_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_mul4x8x8_wallace.sv
// Scoreboard bench for mul4x8x8_wallace: directed corners, random traffic, mid-flight reset.
`timescale 1ns/1ps
module tb_mul4x8x8_wallace;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic [17:0] out_sum;

  typedef struct {
    logic [17:0] sum;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cycle;
  int   n_checks;
  int   n_fail;
  int   n_in;
  int   n_out;

  mul4x8x8_wallace dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [17:0] dot(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(a[8*k +: 8]) * int'(b[8*k +: 8]);
    return s[17:0];
  endfunction

  // Sampled at the next posedge (cycle C+1); result due after three more edges.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [17:0] exp);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    if (v) begin
      e.sum = exp;
      e.due = cycle + 4;
      q.push_back(e);
      n_in++;
      $display("IN  cycle %0d a=%08h b=%08h exp=%0d", cycle, a, b, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      n_out++;
      if (q.size() == 0) begin
        chk("spurious_pulse", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        $display("OUT cycle %0d sum=%0d exp=%0d", cycle, out_sum, e.sum);
        chk("sum", 32'(out_sum), 32'(e.sum));
        chk("latency", cycle, e.due);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rv;
    n_checks = 0;
    n_fail   = 0;
    n_in     = 0;
    n_out    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    rst_n = 1'b1;

    drive(1'b1, 32'h00000000, 32'h00000000, 18'd0);
    drive(1'b0, 32'h0, 32'h0, 18'd0);
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd260100);
    drive(1'b1, 32'h000000FF, 32'h000000FF, 18'd65025);
    drive(1'b1, 32'hFF000000, 32'h00FFFFFF, 18'd0);
    drive(1'b1, 32'h12345678, 32'h87654321, 18'd17404);
    repeat (6) drive(1'b0, 32'h0, 32'h0, 18'd0);
    chk("hold_sum", 32'(out_sum), 32'd17404);
    chk("hold_valid", 32'(out_valid), 32'd0);
    drain();

    for (int i = 0; i < 10000; i++) begin
      rv = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      drive(rv, ra, rb, dot(ra, rb));
    end
    drive(1'b0, 32'h0, 32'h0, 18'd0);
    drain();
    chk("io_count", n_out, n_in);

    // Two results in flight, then an asynchronous reset between clock edges.
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd260100);
    drive(1'b1, 32'h12345678, 32'h87654321, 18'd17404);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(out_sum), 32'd0);
    n_in = n_in - q.size();
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    drive(1'b1, 32'h000000FF, 32'h000000FF, 18'd65025);
    repeat (8) drive(1'b0, 32'h0, 32'h0, 18'd0);
    drain();
    chk("post_rst_count", n_out, n_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
